// File: rtl/csn_challenge_extract_pkg.sv
// Shared encodings for the challenge extractor: FSM states, the rejected pair code, SM3 digest width.
package csn_challenge_extract_pkg;

   localparam int SM3_DIGEST_W = 256;
   localparam logic [1:0] TRIT_REJECT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_EXTRACT,
      S_MORE,
      S_DONE
   } state_t;

endpackage

// File: rtl/csn_challenge_extract_pair_pick.sv
// Combinational selector: picks digest pair i (MSB first) and flags it as a usable trit.
module csn_challenge_extract_pair_pick
   import csn_challenge_extract_pkg::*;
#(
   parameter int DIGEST_W = SM3_DIGEST_W,
   parameter int IDX_W    = $clog2(DIGEST_W / 2)
) (
   input  logic [DIGEST_W-1:0] i_digest,
   input  logic [IDX_W-1:0]    i_pair_idx,
   output logic [1:0]          o_pair,
   output logic                o_valid
);

   logic [DIGEST_W-1:0] w_shifted;

   // Shifting left by 2*idx brings the selected pair to the top two bits.
   assign w_shifted = i_digest << {i_pair_idx, 1'b0};
   assign o_pair    = w_shifted[DIGEST_W-1 -: 2];
   assign o_valid   = (o_pair != TRIT_REJECT);

endmodule

// File: rtl/csn_challenge_extract.sv
// Turns SM3 digests into NUM_ROUNDS challenge trits, one digest pair per cycle, re-hashing on exhaustion.
// Start low aborts and clears; a new digest is accepted only after hash_done has been seen low.
module csn_challenge_extract
   import csn_challenge_extract_pkg::*;
#(
   parameter int NUM_ROUNDS = 64,
   parameter int DIGEST_W   = SM3_DIGEST_W
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic [DIGEST_W-1:0]     i_hash_value,
   input  logic                    i_hash_done,
   output logic                    o_rehash_req,
   output logic [2*NUM_ROUNDS-1:0] o_challenge,
   output logic [7:0]              o_ch_count,
   output logic                    o_busy,
   output logic                    o_ch_done
);

   localparam int         PAIRS    = DIGEST_W / 2;
   localparam int         IDX_W    = $clog2(PAIRS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAIRS - 1);
   localparam logic [7:0] ROUNDS_C = 8'(NUM_ROUNDS);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [DIGEST_W-1:0]     r_digest;
   logic [IDX_W-1:0]        r_pair_idx;
   logic [7:0]              r_ch_count;
   logic [2*NUM_ROUNDS-1:0] r_challenge;
   logic                    r_ch_done;
   logic                    r_rehash_req;
   logic                    r_armed;

   logic [1:0]              w_pair;
   logic                    w_valid;
   logic                    w_latch;
   logic                    w_accept;
   logic [7:0]              w_cnt_next;

   csn_challenge_extract_pair_pick #(
      .DIGEST_W (DIGEST_W),
      .IDX_W    (IDX_W)
   ) u_pair_pick (
      .i_digest   (r_digest),
      .i_pair_idx (r_pair_idx),
      .o_pair     (w_pair),
      .o_valid    (w_valid)
   );

   // r_armed guards against a hash_done level left over from an earlier digest.
   assign w_latch    = i_start && (r_state == S_WAIT) && i_hash_done && r_armed;
   assign w_accept   = i_start && (r_state == S_EXTRACT) && w_valid && (r_ch_count != ROUNDS_C);
   assign w_cnt_next = w_accept ? r_ch_count + 8'd1 : r_ch_count;

   always_comb begin
      w_state_nxt = r_state;
      if (!i_start) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (!r_ch_done) w_state_nxt = S_WAIT;
            S_WAIT:    if (w_latch) w_state_nxt = S_EXTRACT;
            S_EXTRACT: begin
               if (w_cnt_next == ROUNDS_C)     w_state_nxt = S_DONE;
               else if (r_pair_idx == LAST_IDX) w_state_nxt = S_MORE;
            end
            S_MORE:    if (!i_hash_done) w_state_nxt = S_WAIT;
            S_DONE:    w_state_nxt = S_DONE;
            default:   w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_digest     <= '0;
         r_pair_idx   <= '0;
         r_ch_count   <= '0;
         r_challenge  <= '0;
         r_ch_done    <= 1'b0;
         r_rehash_req <= 1'b0;
         r_armed      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_rehash_req <= (r_state == S_EXTRACT) && (w_state_nxt == S_MORE);

         if (w_latch)           r_armed <= 1'b0;
         else if (!i_hash_done) r_armed <= 1'b1;

         if (!i_start) begin
            r_pair_idx  <= '0;
            r_ch_count  <= '0;
            r_challenge <= '0;
            r_ch_done   <= 1'b0;
         end else begin
            if (w_latch) begin
               r_digest   <= i_hash_value;
               r_pair_idx <= '0;
            end else if (r_state == S_EXTRACT) begin
               r_pair_idx <= r_pair_idx + IDX_W'(1);
            end
            if (w_accept) begin
               r_challenge[{r_ch_count, 1'b0} +: 2] <= w_pair;
            end
            r_ch_count <= w_cnt_next;
            r_ch_done  <= (r_state == S_DONE);
         end
      end
   end

   assign o_rehash_req = r_rehash_req;
   assign o_challenge  = r_challenge;
   assign o_ch_count   = r_ch_count;
   assign o_ch_done    = r_ch_done;
   assign o_busy       = (r_state == S_WAIT) || (r_state == S_EXTRACT) || (r_state == S_MORE);

endmodule

// File: tb/tb_csn_challenge_extract.sv
// Directed bench for the challenge extractor: 64-round and 128-round instances share stimulus.
module tb_csn_challenge_extract;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         hash_done;
   logic [255:0] hash_value;

   logic         reh1, busy1, done1;
   logic [127:0] ch1;
   logic [7:0]   cnt1;
   logic         reh2, busy2, done2;
   logic [255:0] ch2;
   logic [7:0]   cnt2;

   logic         sel;
   logic         w_reh, w_busy, w_done;
   logic [255:0] w_ch;
   logic [7:0]   w_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   csn_challenge_extract #(.NUM_ROUNDS(64)) dut64 (
      .i_clk(clk), .i_reset(reset), .i_start(start),
      .i_hash_value(hash_value), .i_hash_done(hash_done),
      .o_rehash_req(reh1), .o_challenge(ch1), .o_ch_count(cnt1),
      .o_busy(busy1), .o_ch_done(done1)
   );

   csn_challenge_extract #(.NUM_ROUNDS(128)) dut128 (
      .i_clk(clk), .i_reset(reset), .i_start(start),
      .i_hash_value(hash_value), .i_hash_done(hash_done),
      .o_rehash_req(reh2), .o_challenge(ch2), .o_ch_count(cnt2),
      .o_busy(busy2), .o_ch_done(done2)
   );

   assign w_reh  = sel ? reh2  : reh1;
   assign w_busy = sel ? busy2 : busy1;
   assign w_done = sel ? done2 : done1;
   assign w_cnt  = sel ? cnt2  : cnt1;
   assign w_ch   = sel ? ch2   : {128'b0, ch1};

   localparam logic [255:0] ALL_00 = '0;
   localparam logic [255:0] ALL_FF = '1;
   localparam logic [255:0] ALL_55 = {128{2'b01}};
   localparam logic [255:0] ALL_AA = {128{2'b10}};
   localparam logic [255:0] PAT_E4 = {32{8'hE4}};

   typedef struct {
      logic [255:0] d0;
      logic [255:0] d1;
      logic         sel;
      int           cyc;
      int           reh;
      int           cnt;
      logic [255:0] ch;
      string        name;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Trits 2,1,0 repeating: the accepted sequence of an 0xE4-filled digest.
   function automatic logic [255:0] rep3(input int n);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < n; i++) begin
         case (i % 3)
            0:       r[2*i +: 2] = 2'b10;
            1:       r[2*i +: 2] = 2'b01;
            default: r[2*i +: 2] = 2'b00;
         endcase
      end
      return r;
   endfunction

   task automatic run_vec(input vec_t v);
      int  n;
      int  nreh;
      bit  pend;
      bit  fin;
      sel = v.sel;
      @(negedge clk);
      start     = 1'b0;
      hash_done = 1'b0;
      @(negedge clk);
      start      = 1'b1;
      hash_value = v.d0;
      hash_done  = 1'b1;
      n = 0; nreh = 0; pend = 1'b0; fin = 1'b0;
      while (!fin && n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (w_reh) begin
            nreh++;
            hash_done = 1'b0;
            pend      = 1'b1;
         end else if (pend) begin
            pend       = 1'b0;
            hash_value = v.d1;
            hash_done  = 1'b1;
         end
         if (w_done) fin = 1'b1;
      end
      check($sformatf("%s_cycles", v.name), 256'(n), 256'(v.cyc));
      check($sformatf("%s_rehash", v.name), 256'(nreh), 256'(v.reh));
      check($sformatf("%s_count", v.name), 256'(w_cnt), 256'(v.cnt));
      check($sformatf("%s_challenge", v.name), w_ch, v.ch);
      check($sformatf("%s_busy", v.name), 256'(w_busy), 256'(0));
   endtask

   initial begin
      int n;
      bit fin;

      vecs[0] = '{ALL_00, ALL_00, 1'b0, 67, 0, 64, ALL_00, "zeros"};
      vecs[1] = '{PAT_E4, ALL_00, 1'b0, 89, 0, 64, rep3(64), "e4"};
      vecs[2] = '{ALL_FF, ALL_55, 1'b0, 197, 1, 64, {128'b0, {64{2'b01}}}, "ff_then_55"};
      vecs[3] = '{ALL_AA, ALL_00, 1'b0, 67, 0, 64, {128'b0, {64{2'b10}}}, "aa"};
      vecs[4] = '{{{64{2'b11}}, {64{2'b01}}}, ALL_00, 1'b0, 131, 0, 64,
                  {128'b0, {64{2'b01}}}, "late_valid"};
      vecs[5] = '{{{96{2'b11}}, {32{2'b01}}}, ALL_AA, 1'b0, 165, 1, 64,
                  {128'b0, {32{2'b10}}, {32{2'b01}}}, "split"};
      vecs[6] = '{ALL_AA, ALL_00, 1'b1, 131, 0, 128, ALL_AA, "r128_last_pair"};

      sel        = 1'b0;
      reset      = 1'b1;
      start      = 1'b0;
      hash_done  = 1'b0;
      hash_value = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_count", 256'(cnt1), 256'(0));
      check("reset_challenge", {128'b0, ch1}, ALL_00);
      check("reset_flags", 256'({reh1, busy1, done1}), 256'(0));
      reset = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Abort after 10 trits, then a clean restart.
      sel = 1'b0;
      @(negedge clk);
      start = 1'b0; hash_done = 1'b0;
      @(negedge clk);
      start = 1'b1; hash_value = ALL_AA; hash_done = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("abort_pre_count", 256'(cnt1), 256'(10));
      check("abort_pre_challenge", {128'b0, ch1}, 256'({10{2'b10}}));
      start = 1'b0;
      @(posedge clk);
      #1;
      check("abort_count", 256'(cnt1), 256'(0));
      check("abort_challenge", {128'b0, ch1}, ALL_00);
      check("abort_flags", 256'({reh1, busy1, done1}), 256'(0));
      run_vec(vecs[1]);

      // Reset mid-extraction with hash_done held; the stale level must not be re-used.
      @(negedge clk);
      start = 1'b0; hash_done = 1'b0;
      @(negedge clk);
      start = 1'b1; hash_value = PAT_E4; hash_done = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midreset_count", 256'(cnt1), 256'(0));
      check("midreset_challenge", {128'b0, ch1}, ALL_00);
      check("midreset_flags", 256'({reh1, busy1, done1}), 256'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("stale_count", 256'(cnt1), 256'(0));
      check("stale_busy", 256'(busy1), 256'(1));
      hash_done = 1'b0;
      @(posedge clk);
      #1;
      hash_value = ALL_AA;
      hash_done  = 1'b1;
      n = 0; fin = 1'b0;
      while (!fin && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (reh1) check("fresh_no_rehash", 256'(reh1), 256'(0));
         if (done1) fin = 1'b1;
      end
      check("fresh_cycles", 256'(n), 256'(66));
      check("fresh_count", 256'(cnt1), 256'(64));
      check("fresh_challenge", {128'b0, ch1}, {128'b0, {64{2'b10}}});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
